mandel_julia_solver: RTL and testbench

MANDEL_JULIA_SOLVER -- requirements
Module: mandel_julia_solver

---
 rtl/mandel_julia_solver_if.sv | 31 +++
 rtl/mandel_julia_solver.sv | 152 +++++++++++++++
 tb/tb_mandel_julia_solver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_julia_solver_if.sv
// Job-control and register-write bus for the Mandelbrot/Julia escape-time solver.
interface mandel_julia_solver_if #(
  parameter int WIDTH     = 16,
  parameter int ITER_BITS = 16
);
  logic                 wr_real_en;
  logic                 wr_imag_en;
  logic                 wr_const_en;
  logic [WIDTH-1:0]     real_data;
  logic [WIDTH-1:0]     imag_data;
  logic                 wr_iter_lim_en;
  logic [ITER_BITS-1:0] iter_lim_data;
  logic                 julia_mode;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 out_ready;
  logic [ITER_BITS-1:0] iterations;

  modport master (
    output wr_real_en, wr_imag_en, wr_const_en, real_data, imag_data,
           wr_iter_lim_en, iter_lim_data, julia_mode, start, abort,
    input  busy, out_ready, iterations
  );

  modport slave (
    input  wr_real_en, wr_imag_en, wr_const_en, real_data, imag_data,
           wr_iter_lim_en, iter_lim_data, julia_mode, start, abort,
    output busy, out_ready, iterations
  );
endinterface

// File: rtl/mandel_julia_solver.sv
// Fixed-point escape-time iterator: one z <- z^2 + c step per clock, Mandelbrot or Julia.
module mandel_julia_solver #(
  parameter int WIDTH             = 16,
  parameter int FRAC_BITS         = 12,
  parameter int ITER_BITS         = 16,
  parameter int DIVERGENCE_RADIUS = 4
) (
  input logic                  clock,
  input logic                  reset,
  mandel_julia_solver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  localparam logic [2*WIDTH:0] RADIUS_SQ =
    (2*WIDTH+1)'(DIVERGENCE_RADIUS) << (2*FRAC_BITS);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     pt_re_q, pt_re_d, pt_im_q, pt_im_d;
  logic [WIDTH-1:0]     k_re_q, k_re_d, k_im_q, k_im_d;
  logic [WIDTH-1:0]     z_re_q, z_re_d, z_im_q, z_im_d;
  logic [WIDTH-1:0]     c_re_q, c_re_d, c_im_q, c_im_d;
  logic [ITER_BITS-1:0] limit_q, limit_d, count_q, count_d;
  logic [ITER_BITS-1:0] iterations_q, iterations_d;
  logic                 busy_q, busy_d, out_ready_q, out_ready_d;

  logic signed [2*WIDTH-1:0] zr_sq, zi_sq, zri;
  logic signed [2*WIDTH:0]   diff, twice, re_shift, im_shift;
  logic [2*WIDTH:0]          mag;
  logic                      escaped;

  // Squares are non-negative, so zero-extending them gives an exact, wrap-free magnitude.
  always_comb begin
    zr_sq    = $signed(z_re_q) * $signed(z_re_q);
    zi_sq    = $signed(z_im_q) * $signed(z_im_q);
    zri      = $signed(z_re_q) * $signed(z_im_q);
    mag      = {1'b0, zr_sq} + {1'b0, zi_sq};
    escaped  = mag > RADIUS_SQ;
    diff     = {zr_sq[2*WIDTH-1], zr_sq} - {zi_sq[2*WIDTH-1], zi_sq};
    twice    = {zri, 1'b0};
    re_shift = diff >>> FRAC_BITS;
    im_shift = twice >>> FRAC_BITS;
  end

  always_comb begin
    state_d      = state_q;
    pt_re_d      = pt_re_q;
    pt_im_d      = pt_im_q;
    k_re_d       = k_re_q;
    k_im_d       = k_im_q;
    z_re_d       = z_re_q;
    z_im_d       = z_im_q;
    c_re_d       = c_re_q;
    c_im_d       = c_im_q;
    limit_d      = limit_q;
    count_d      = count_q;
    iterations_d = iterations_q;
    busy_d       = busy_q;
    out_ready_d  = out_ready_q;

    if (state_q != ITERATE) begin
      if (bus.wr_real_en)     pt_re_d = bus.real_data;
      if (bus.wr_imag_en)     pt_im_d = bus.imag_data;
      if (bus.wr_const_en) begin
        k_re_d = bus.real_data;
        k_im_d = bus.imag_data;
      end
      if (bus.wr_iter_lim_en) limit_d = bus.iter_lim_data;
    end

    // limit_q doubles as the job limit: writes are blocked while iterating.
    case (state_q)
      ITERATE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (escaped || count_q == limit_q) begin
          state_d      = DONE;
          iterations_d = count_q;
          busy_d       = 1'b0;
          out_ready_d  = 1'b1;
        end else begin
          z_re_d  = re_shift[WIDTH-1:0] + c_re_q;
          z_im_d  = im_shift[WIDTH-1:0] + c_im_q;
          count_d = count_q + ITER_BITS'(1);
        end
      end
      default: begin
        if (bus.abort) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          out_ready_d = 1'b0;
        end else if (bus.start) begin
          state_d     = ITERATE;
          busy_d      = 1'b1;
          out_ready_d = 1'b0;
          count_d     = '0;
          if (bus.julia_mode) begin
            z_re_d = pt_re_q;
            z_im_d = pt_im_q;
            c_re_d = k_re_q;
            c_im_d = k_im_q;
          end else begin
            z_re_d = '0;
            z_im_d = '0;
            c_re_d = pt_re_q;
            c_im_d = pt_im_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pt_re_q      <= '0;
      pt_im_q      <= '0;
      k_re_q       <= '0;
      k_im_q       <= '0;
      z_re_q       <= '0;
      z_im_q       <= '0;
      c_re_q       <= '0;
      c_im_q       <= '0;
      limit_q      <= '0;
      count_q      <= '0;
      iterations_q <= '0;
      busy_q       <= 1'b0;
      out_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pt_re_q      <= pt_re_d;
      pt_im_q      <= pt_im_d;
      k_re_q       <= k_re_d;
      k_im_q       <= k_im_d;
      z_re_q       <= z_re_d;
      z_im_q       <= z_im_d;
      c_re_q       <= c_re_d;
      c_im_q       <= c_im_d;
      limit_q      <= limit_d;
      count_q      <= count_d;
      iterations_q <= iterations_d;
      busy_q       <= busy_d;
      out_ready_q  <= out_ready_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out_ready  = out_ready_q;
  assign bus.iterations = iterations_q;

endmodule

// File: tb/tb_mandel_julia_solver.sv
// Directed-vector bench for mandel_julia_solver (Q4.12, radius 4).
module tb_mandel_julia_solver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mandel_julia_solver_if #(.WIDTH(16), .ITER_BITS(16)) bus ();

  mandel_julia_solver #(
    .WIDTH(16), .FRAC_BITS(12), .ITER_BITS(16), .DIVERGENCE_RADIUS(4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  task automatic setup(input logic mode, input logic [15:0] re, input logic [15:0] im,
                       input logic [15:0] lim);
    @(negedge clk);
    bus.julia_mode     = mode;
    bus.wr_real_en     = 1'b1;
    bus.wr_imag_en     = 1'b1;
    bus.real_data      = re;
    bus.imag_data      = im;
    bus.wr_iter_lim_en = 1'b1;
    bus.iter_lim_data  = lim;
    @(negedge clk);
    bus.wr_real_en     = 1'b0;
    bus.wr_imag_en     = 1'b0;
    bus.wr_iter_lim_en = 1'b0;
  endtask

  task automatic run_job(output int cycles, output logic busy0);
    @(negedge clk);
    bus.start = 1'b1;
    cycles    = 0;
    @(posedge clk);
    cycles++;
    #1 bus.start = 1'b0;
    busy0 = bus.busy;
    while (!bus.out_ready && cycles < 300) begin
      @(posedge clk);
      cycles++;
      #1;
    end
  endtask

  task automatic test_reset();
    bus.wr_real_en = 0; bus.wr_imag_en = 0; bus.wr_const_en = 0;
    bus.real_data = '0; bus.imag_data = '0; bus.wr_iter_lim_en = 0;
    bus.iter_lim_data = '0; bus.julia_mode = 0; bus.start = 0; bus.abort = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_ready !== 1'b0 || bus.iterations !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b rdy=%b it=%0d exp 0/0/0", bus.busy, bus.out_ready, bus.iterations);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mandel_escape();
    int cyc; logic b0;
    setup(1'b0, 16'h2000, 16'h0000, 16'd10);
    run_job(cyc, b0);
    checks++;
    if (b0 !== 1'b1) begin failures++; $display("FAIL escape_busy got=%b exp=1", b0); end
    checks++;
    if (bus.out_ready !== 1'b1 || bus.iterations !== 16'd2) begin
      failures++; $display("FAIL escape_iter got rdy=%b it=%0d exp rdy=1 it=2", bus.out_ready, bus.iterations);
    end
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL escape_latency got=%0d exp=4", cyc); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_ready !== 1'b1 || bus.iterations !== 16'd2 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL done_stable got rdy=%b it=%0d busy=%b exp 1/2/0", bus.out_ready, bus.iterations, bus.busy);
    end
  endtask

  task automatic test_mandel_bounded();
    int cyc; logic b0;
    logic [15:0] pts [2] = '{16'hE000, 16'h0000};
    foreach (pts[i]) begin
      setup(1'b0, pts[i], 16'h0000, 16'd10);
      run_job(cyc, b0);
      checks++;
      if (bus.iterations !== 16'd10 || cyc !== 12) begin
        failures++; $display("FAIL bounded_%0d got it=%0d lat=%0d exp it=10 lat=12", i, bus.iterations, cyc);
      end
    end
  endtask

  task automatic test_julia();
    int cyc; logic b0;
    @(negedge clk);
    bus.wr_const_en = 1'b1; bus.real_data = '0; bus.imag_data = '0;
    @(negedge clk);
    bus.wr_const_en = 1'b0;
    setup(1'b1, 16'h1800, 16'h0000, 16'd10);
    run_job(cyc, b0);
    checks++;
    if (bus.iterations !== 16'd1 || cyc !== 3) begin
      failures++; $display("FAIL julia_escape got it=%0d lat=%0d exp it=1 lat=3", bus.iterations, cyc);
    end
    setup(1'b1, 16'h1800, 16'h0000, 16'd0);
    run_job(cyc, b0);
    checks++;
    if (bus.iterations !== 16'd0 || cyc !== 2 || bus.out_ready !== 1'b1) begin
      failures++; $display("FAIL julia_limit0 got it=%0d lat=%0d rdy=%b exp it=0 lat=2 rdy=1", bus.iterations, cyc, bus.out_ready);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic b0;
    setup(1'b0, 16'h2000, 16'h0000, 16'd10);
    for (int n = 0; n < 4; n++) begin
      run_job(cyc, b0);
      checks++;
      if (bus.iterations !== 16'd2 || cyc !== 4) begin
        failures++; $display("FAIL back_to_back_%0d got it=%0d lat=%0d exp it=2 lat=4", n, bus.iterations, cyc);
      end
    end
  endtask

  task automatic test_abort();
    int bad = 0;
    setup(1'b0, 16'h0000, 16'h0000, 16'd100);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_ready !== 1'b0 || bus.iterations !== 16'd2) begin
      failures++; $display("FAIL abort_state got busy=%b rdy=%b it=%0d exp 0/0/2", bus.busy, bus.out_ready, bus.iterations);
    end
    repeat (110) begin @(posedge clk); #1 if (bus.out_ready !== 1'b0 || bus.busy !== 1'b0) bad++; end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL abort_quiet got bad_cycles=%0d exp=0", bad); end
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
    bad = 0;
    repeat (5) begin if (bus.busy !== 1'b0 || bus.out_ready !== 1'b0) bad++; @(posedge clk); #1; end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL start_abort got bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_write_during_iterate();
    int cyc = 0; logic b0;
    setup(1'b0, 16'h2000, 16'h0000, 16'd10);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); cyc++; #1 bus.start = 1'b0;
    @(negedge clk);
    bus.wr_real_en = 1'b1; bus.wr_imag_en = 1'b1; bus.wr_iter_lim_en = 1'b1;
    bus.real_data = '0; bus.imag_data = '0; bus.iter_lim_data = '0;
    @(posedge clk); cyc++; #1;
    bus.wr_real_en = 1'b0; bus.wr_imag_en = 1'b0; bus.wr_iter_lim_en = 1'b0;
    while (!bus.out_ready && cyc < 300) begin @(posedge clk); cyc++; #1; end
    checks++;
    if (bus.iterations !== 16'd2 || cyc !== 4) begin
      failures++; $display("FAIL write_in_iter got it=%0d lat=%0d exp it=2 lat=4", bus.iterations, cyc);
    end
    run_job(cyc, b0);
    checks++;
    if (bus.iterations !== 16'd2 || cyc !== 4) begin
      failures++; $display("FAIL write_ignored_regs got it=%0d lat=%0d exp it=2 lat=4", bus.iterations, cyc);
    end
  endtask

  task automatic test_reset_mid_job();
    int bad = 0; int cyc; logic b0;
    setup(1'b0, 16'h0000, 16'h0000, 16'd100);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_ready !== 1'b0 || bus.iterations !== 16'd0) begin
      failures++; $display("FAIL reset_mid_job got busy=%b rdy=%b it=%0d exp 0/0/0", bus.busy, bus.out_ready, bus.iterations);
    end
    #4 rst = 1'b0;
    repeat (20) begin @(posedge clk); #1 if (bus.out_ready !== 1'b0 || bus.busy !== 1'b0) bad++; end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL reset_quiet got bad_cycles=%0d exp=0", bad); end
    run_job(cyc, b0);
    checks++;
    if (bus.iterations !== 16'd0 || cyc !== 2) begin
      failures++; $display("FAIL reset_limit_cleared got it=%0d lat=%0d exp it=0 lat=2", bus.iterations, cyc);
    end
    @(negedge clk); bus.wr_iter_lim_en = 1'b1; bus.iter_lim_data = 16'd10;
    @(negedge clk); bus.wr_iter_lim_en = 1'b0;
    run_job(cyc, b0);
    checks++;
    if (bus.iterations !== 16'd10 || cyc !== 12) begin
      failures++; $display("FAIL reset_point_cleared got it=%0d lat=%0d exp it=10 lat=12", bus.iterations, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_mandel_escape();
    test_mandel_bounded();
    test_julia();
    test_back_to_back();
    test_abort();
    test_write_during_iterate();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
